// File: rtl/bullet_controller.sv
// Player bullet engine: launches one bullet on a fire edge, moves it up once per frame,
// retires it on an enemy hit or top-of-screen exit, then holds off for a cooldown.
module bullet_controller #(
    parameter int BULLET_LEN      = 4,
    parameter int BULLET_STEP     = 4,
    parameter int PLAYER_Y        = 440,
    parameter int MUZZLE_OFS      = 8,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       fire,
    input  logic [9:0] playerX,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       hit,
    output logic       bullet_active,
    output logic [9:0] bulletX,
    output logic [9:0] bulletY,
    output logic       bullet_on,
    output logic       enemy_kill
);

    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [9:0]    STEP_V  = 10'(BULLET_STEP);
    localparam logic [9:0]    SPAWN_Y = 10'(PLAYER_Y - BULLET_LEN);
    localparam logic [9:0]    MUZZLE  = 10'(MUZZLE_OFS);
    localparam logic [10:0]   LEN_V   = 11'(BULLET_LEN);
    localparam logic [CW-1:0] COOL_V  = CW'(COOLDOWN_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLYING   = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [9:0]    bullet_x_q, bullet_x_d;
    logic [9:0]    bullet_y_q, bullet_y_d;
    logic [CW-1:0] cool_cnt_q, cool_cnt_d;
    logic          fire_pend_q, fire_pend_d;
    logic          fire_prev_q, fire_prev_d;
    logic          frame_sync1_q, frame_sync1_d;
    logic          frame_sync2_q, frame_sync2_d;
    logic          frame_prev_q, frame_prev_d;
    logic          enemy_kill_q, enemy_kill_d;
    logic          frame_tick;
    logic          fire_rise;
    logic [10:0]   y_ext;
    logic [10:0]   y_end;

    assign frame_tick = frame_sync2_q & ~frame_prev_q;
    assign fire_rise  = fire & ~fire_prev_q;

    // Next-state, coordinate and cooldown logic
    always_comb begin
        state_d       = state_q;
        bullet_x_d    = bullet_x_q;
        bullet_y_d    = bullet_y_q;
        cool_cnt_d    = cool_cnt_q;
        enemy_kill_d  = 1'b0;
        fire_prev_d   = fire;
        frame_sync1_d = frame_clk;
        frame_sync2_d = frame_sync1_q;
        frame_prev_d  = frame_sync2_q;

        // Edges outside IDLE are dropped so a held key never auto-fires
        if ((state_q == ST_IDLE) && fire_rise) begin
            fire_pend_d = 1'b1;
        end else begin
            fire_pend_d = fire_pend_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_tick && fire_pend_q) begin
                    bullet_x_d  = playerX + MUZZLE;
                    bullet_y_d  = SPAWN_Y;
                    fire_pend_d = 1'b0;
                    state_d     = ST_FLYING;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLYING: begin
                if (hit) begin
                    enemy_kill_d = 1'b1;
                    cool_cnt_d   = COOL_V;
                    state_d      = ST_COOLDOWN;
                end else if (frame_tick) begin
                    if (bullet_y_q < STEP_V) begin
                        cool_cnt_d = COOL_V;
                        state_d    = ST_COOLDOWN;
                    end else begin
                        bullet_y_d = bullet_y_q - STEP_V;
                    end
                end else begin
                    state_d = ST_FLYING;
                end
            end
            ST_COOLDOWN: begin
                if (frame_tick) begin
                    cool_cnt_d = cool_cnt_q - CW'(1);
                    if (cool_cnt_q <= CW'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_COOLDOWN;
                    end
                end else begin
                    state_d = ST_COOLDOWN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and pipeline registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            bullet_x_q    <= 10'd0;
            bullet_y_q    <= 10'd0;
            cool_cnt_q    <= '0;
            fire_pend_q   <= 1'b0;
            fire_prev_q   <= 1'b0;
            frame_sync1_q <= 1'b0;
            frame_sync2_q <= 1'b0;
            frame_prev_q  <= 1'b0;
            enemy_kill_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            bullet_x_q    <= bullet_x_d;
            bullet_y_q    <= bullet_y_d;
            cool_cnt_q    <= cool_cnt_d;
            fire_pend_q   <= fire_pend_d;
            fire_prev_q   <= fire_prev_d;
            frame_sync1_q <= frame_sync1_d;
            frame_sync2_q <= frame_sync2_d;
            frame_prev_q  <= frame_prev_d;
            enemy_kill_q  <= enemy_kill_d;
        end
    end

    // Window end held at 11 bits so rows near 1023 do not wrap
    assign y_ext = {1'b0, bullet_y_q};
    assign y_end = y_ext + LEN_V;

    assign bullet_active = (state_q == ST_FLYING);
    assign bulletX       = bullet_x_q;
    assign bulletY       = bullet_y_q;
    assign enemy_kill    = enemy_kill_q;
    assign bullet_on     = bullet_active && (DrawX == bullet_x_q) &&
                           ({1'b0, DrawY} >= y_ext) && ({1'b0, DrawY} < y_end);

endmodule

// File: tb/tb_bullet_controller.sv
// Self-checking bench for bullet_controller: directed scenarios plus randomized flights
// compared against an arithmetic model of bullet position and pixel window.
module tb_bullet_controller;

    logic       Clk = 1'b0;
    logic       Reset, frame_clk, fire, hit;
    logic [9:0] playerX, DrawX, DrawY;
    logic       bullet_active, bullet_on, enemy_kill;
    logic [9:0] bulletX, bulletY;

    int checks = 0;
    int errors = 0;
    int kills = 0;
    int exp_kills = 0;
    int m_x = 0;
    int m_y = 0;

    bullet_controller dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .fire(fire),
        .playerX(playerX), .DrawX(DrawX), .DrawY(DrawY), .hit(hit),
        .bullet_active(bullet_active), .bulletX(bulletX), .bulletY(bulletY),
        .bullet_on(bullet_on), .enemy_kill(enemy_kill)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (enemy_kill === 1'b1) kills++;
    end

    task automatic tick();
        frame_clk = 1'b1;
        repeat (4) @(posedge Clk);
        #1 frame_clk = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic fire_pulse();
        fire = 1'b1;
        @(posedge Clk);
        #1 fire = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    task automatic launch(input int px);
        playerX = 10'(px);
        fire_pulse();
        tick();
        m_x = (px + 8) % 1024;
        m_y = 436;
    endtask

    task automatic fly(input int n);
        repeat (n) tick();
        m_y = m_y - 4 * n;
    endtask

    task automatic hit_for(input int n);
        hit = 1'b1;
        repeat (n) @(posedge Clk);
        #1 hit = 1'b0;
        exp_kills++;
    endtask

    task automatic cooldown();
        repeat (8) tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1; fire = 1'b0; hit = 1'b0; frame_clk = 1'b0;
        playerX = 10'd0; DrawX = 10'd0; DrawY = 10'd0;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if ({bullet_active, bulletX, bulletY, enemy_kill, bullet_on} !== {1'b0, 10'd0, 10'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got act=%0b x=%0d y=%0d kill=%0b on=%0b exp all 0",
                     bullet_active, bulletX, bulletY, enemy_kill, bullet_on);
        end
        Reset = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_launch_top_exit();
        launch(100);
        checks++;
        if ({bullet_active, bulletX, bulletY} !== {1'b1, 10'(m_x), 10'(m_y)}) begin
            errors++;
            $display("FAIL launch got act=%0b x=%0d y=%0d exp 1 %0d %0d", bullet_active, bulletX, bulletY, m_x, m_y);
        end
        fly(109);
        checks++;
        if ({bullet_active, bulletY} !== {1'b1, 10'(m_y)}) begin
            errors++;
            $display("FAIL top_reach got act=%0b y=%0d exp 1 %0d", bullet_active, bulletY, m_y);
        end
        tick();
        checks++;
        if (bullet_active !== 1'b0 || kills != exp_kills) begin
            errors++;
            $display("FAIL top_exit got act=%0b kills=%0d exp 0 %0d", bullet_active, kills, exp_kills);
        end
        cooldown();
    endtask

    task automatic test_window_and_hit();
        logic exp_on;
        launch(42);
        fly(34);
        checks++;
        if ({bulletX, bulletY} !== {10'(m_x), 10'(m_y)}) begin
            errors++;
            $display("FAIL window_pos got x=%0d y=%0d exp %0d %0d", bulletX, bulletY, m_x, m_y);
        end
        for (int dx = 49; dx <= 51; dx++) begin
            for (int dy = 299; dy <= 304; dy++) begin
                DrawX = 10'(dx); DrawY = 10'(dy);
                #1;
                exp_on = (dx == m_x) && (dy >= m_y) && (dy < m_y + 4);
                checks++;
                if (bullet_on !== exp_on) begin
                    errors++;
                    $display("FAIL window_on x=%0d y=%0d got %0b exp %0b", dx, dy, bullet_on, exp_on);
                end
            end
        end
        hit_for(5);
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if ({bullet_active, enemy_kill, bulletX, bulletY} !== {1'b0, 1'b0, 10'(m_x), 10'(m_y)} || kills != exp_kills) begin
            errors++;
            $display("FAIL hit_single got act=%0b kill=%0b x=%0d y=%0d kills=%0d exp 0 0 %0d %0d %0d",
                     bullet_active, enemy_kill, bulletX, bulletY, kills, m_x, m_y, exp_kills);
        end
        repeat (7) tick();
        fire_pulse();
        tick();
        checks++;
        if (bullet_active !== 1'b0) begin
            errors++;
            $display("FAIL cooldown_len got act=%0b exp 0", bullet_active);
        end
        launch(42);
        checks++;
        if ({bullet_active, bulletX, bulletY} !== {1'b1, 10'(m_x), 10'(m_y)}) begin
            errors++;
            $display("FAIL post_cooldown_launch got act=%0b x=%0d y=%0d exp 1 %0d %0d", bullet_active, bulletX, bulletY, m_x, m_y);
        end
        hit_for(1);
        cooldown();
    endtask

    task automatic test_collision();
        launch(200);
        fly(59);
        frame_clk = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        #1 hit = 1'b1;
        @(posedge Clk);
        #1 hit = 1'b0;
        exp_kills++;
        checks++;
        if ({enemy_kill, bullet_active, bulletY} !== {1'b1, 1'b0, 10'd200}) begin
            errors++;
            $display("FAIL collision got kill=%0b act=%0b y=%0d exp 1 0 200", enemy_kill, bullet_active, bulletY);
        end
        frame_clk = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (kills != exp_kills) begin
            errors++;
            $display("FAIL collision_kills got %0d exp %0d", kills, exp_kills);
        end
        cooldown();
    endtask

    task automatic test_fire_hold();
        playerX = 10'd200;
        fire = 1'b1;
        @(posedge Clk);
        #1;
        tick();
        m_x = 208; m_y = 436;
        checks++;
        if ({bullet_active, bulletX, bulletY} !== {1'b1, 10'(m_x), 10'(m_y)}) begin
            errors++;
            $display("FAIL hold_launch got act=%0b x=%0d y=%0d exp 1 %0d %0d", bullet_active, bulletX, bulletY, m_x, m_y);
        end
        fly(3);
        fire = 1'b0;
        @(posedge Clk);
        #1 fire = 1'b1;
        @(posedge Clk);
        #1;
        hit_for(1);
        cooldown();
        tick();
        tick();
        checks++;
        if (bullet_active !== 1'b0) begin
            errors++;
            $display("FAIL hold_no_refire got act=%0b exp 0", bullet_active);
        end
        fire = 1'b0;
        @(posedge Clk);
        #1;
        launch(200);
        checks++;
        if ({bullet_active, bulletX} !== {1'b1, 10'(m_x)}) begin
            errors++;
            $display("FAIL fresh_edge_launch got act=%0b x=%0d exp 1 %0d", bullet_active, bulletX, m_x);
        end
        hit_for(1);
        cooldown();
    endtask

    task automatic test_reset_midflight();
        launch(300);
        fly(2);
        #3 Reset = 1'b1;
        #1;
        checks++;
        if ({bullet_active, bulletX, bulletY} !== {1'b0, 10'd0, 10'd0}) begin
            errors++;
            $display("FAIL reset_midflight got act=%0b x=%0d y=%0d exp 0 0 0", bullet_active, bulletX, bulletY);
        end
        @(posedge Clk);
        #1 Reset = 1'b0;
        @(posedge Clk);
        #1;
        fire_pulse();
        Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        @(posedge Clk);
        #1;
        tick();
        checks++;
        if (bullet_active !== 1'b0) begin
            errors++;
            $display("FAIL reset_pend_lost got act=%0b exp 0", bullet_active);
        end
    endtask

    task automatic test_random();
        int px, k, dx, dy;
        logic exp_on;
        for (int it = 0; it < 6; it++) begin
            px = (it == 0) ? 1020 : int'($urandom_range(0, 1023));
            k  = int'($urandom_range(0, 108));
            launch(px);
            fly(k);
            checks++;
            if ({bullet_active, bulletX, bulletY} !== {1'b1, 10'(m_x), 10'(m_y)}) begin
                errors++;
                $display("FAIL rand_pos px=%0d k=%0d got act=%0b x=%0d y=%0d exp 1 %0d %0d",
                         px, k, bullet_active, bulletX, bulletY, m_x, m_y);
            end
            for (int p = 0; p < 6; p++) begin
                dx = (m_x + int'($urandom_range(0, 2)) - 1) & 1023;
                dy = m_y + int'($urandom_range(0, 7)) - 2;
                DrawX = 10'(dx); DrawY = 10'(dy);
                #1;
                exp_on = (dx == m_x) && (dy >= m_y) && (dy < m_y + 4);
                checks++;
                if (bullet_on !== exp_on) begin
                    errors++;
                    $display("FAIL rand_on x=%0d y=%0d got %0b exp %0b", dx, dy, bullet_on, exp_on);
                end
            end
            hit_for(1);
            cooldown();
        end
        checks++;
        if (kills != exp_kills) begin
            errors++;
            $display("FAIL total_kills got %0d exp %0d", kills, exp_kills);
        end
    endtask

    initial begin
        test_reset();
        test_launch_top_exit();
        test_window_and_hit();
        test_collision();
        test_fire_hold();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
